// File: rtl/cia_bus_arbiter.sv
// cia_bus_arbiter: shares one CIA (mos6526) register bus between the CPU
// (port 0) and a snapshot/debug unit (port 1). Each granted access becomes a
// single chip-select window aligned to the CIA's phi2 strobes.
//
// Build option: define CIA_ARB_RR_EN for round-robin arbitration between the
// two ports; leave it undefined for fixed priority (port 0 always wins).
//
// Handshake: reqN is a level held by the requester until ackN. ackN is a
// one-clk pulse that marks the access as done. A request dropped after its
// grant still completes and still gets its ack pulse. The arbiter never
// retries an access, so side-effecting reads reach the CIA exactly once.
module cia_bus_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       phi2_p,
  input  logic       phi2_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [3:0] addr0,
  input  logic [3:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       gnt_id,
  output logic       cia_cs_n,
  output logic       cia_rw,
  output logic [3:0] cia_rs,
  output logic [7:0] cia_db_in,
  input  logic [7:0] cia_db_out,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t     state_q;
  logic       cs_n_q;
  logic       rw_q;
  logic [3:0] rs_q;
  logic [7:0] db_in_q;
  logic       ack0_q;
  logic       ack1_q;
  logic [7:0] rdata_q;
  logic       busy_q;
  logic       gnt_q;

  logic       win_d;
  logic       sel_we_d;
  logic [3:0] sel_addr_d;
  logic [7:0] sel_wdata_d;
  logic       any_req;

  assign any_req = req0 | req1;

  // Pick the winning port for the next grant and mux its access fields.
`ifdef CIA_ARB_RR_EN
  // On a contest the port that did not own the last access wins; with
  // gnt_id resetting to 1 the CPU wins the first contest after reset.
  always_comb begin
    win_d = ~req0;
    if (req0 && req1) begin
      win_d = ~gnt_q;
    end
    sel_we_d    = win_d ? we1    : we0;
    sel_addr_d  = win_d ? addr1  : addr0;
    sel_wdata_d = win_d ? wdata1 : wdata0;
  end
`else
  // Fixed priority: the CPU wins whenever it asks; port 1 may starve.
  always_comb begin
    win_d       = ~req0;
    sel_we_d    = win_d ? we1    : we0;
    sel_addr_d  = win_d ? addr1  : addr0;
    sel_wdata_d = win_d ? wdata1 : wdata0;
  end
`endif

  // Access sequencer. All pin-facing signals are registered here. The read
  // capture and the ack are loaded on the phi2_n edge that ends ARMED, so
  // both are visible during CAPTURE, one clk after the phi2_n strobe, and no
  // grant can coincide with an ack. Bus fields (rw/rs/db_in) change only on
  // a grant and otherwise hold their last value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cs_n_q  <= 1'b1;
      rw_q    <= 1'b1;
      rs_q    <= 4'h0;
      db_in_q <= 8'h00;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rdata_q <= 8'h00;
      busy_q  <= 1'b0;
      gnt_q   <= 1'b1;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // phi2_n while idle is meaningless and is ignored.
          if (phi2_p && any_req) begin
            rw_q    <= ~sel_we_d;
            rs_q    <= sel_addr_d;
            db_in_q <= sel_wdata_d;
            gnt_q   <= win_d;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ARMED;
          end
        end
        ARMED: begin
          // A stray phi2_p here is ignored; only phi2_n ends the window.
          // The CIA performs the access in this phi2_n clk.
          if (phi2_n) begin
            cs_n_q  <= 1'b1;
            if (rw_q) begin
              rdata_q <= cia_db_out;
            end
            ack0_q  <= ~gnt_q;
            ack1_q  <= gnt_q;
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          cs_n_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign gnt_id    = gnt_q;
  assign cia_cs_n  = cs_n_q;
  assign cia_rw    = rw_q;
  assign cia_rs    = rs_q;
  assign cia_db_in = db_in_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cia_bus_arbiter.sv
// Testbench for cia_bus_arbiter: random and directed requests from both
// ports against a small CIA register model, with a transaction-level
// reference model feeding an expected queue checked on every ack.
`timescale 1ns/1ps
module tb_cia_bus_arbiter;

  localparam int W = 54; // {port, we, addr[4], wdata[8], rdata_exp[8], ack_cyc[32]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic       phi2_p, phi2_n, req0, req1, we0, we1;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1, busy, gnt_id, cia_cs_n, cia_rw;
  logic [7:0] rdata, cia_db_in, cia_db_out;
  logic [3:0] cia_rs;
  logic [1:0] dbg_state;

  cia_bus_arbiter dut (
    .clk(clk), .reset(reset), .phi2_p(phi2_p), .phi2_n(phi2_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy), .gnt_id(gnt_id),
    .cia_cs_n(cia_cs_n), .cia_rw(cia_rw), .cia_rs(cia_rs),
    .cia_db_in(cia_db_in), .cia_db_out(cia_db_out), .dbg_state(dbg_state)
  );

  // ---------------- CIA register model ----------------
  function automatic logic [7:0] reg_init(input int i);
    logic [3:0] n;
    n = 4'(i);
    return (i == 4) ? 8'h5A : {n, ~n};
  endfunction

  logic [7:0] cia_regs [16];
  int wr_seen = 0;
  int rdd_seen = 0;
  assign cia_db_out = cia_regs[cia_rs];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) cia_regs[i] <= reg_init(i);
    end else if (phi2_n && !cia_cs_n) begin
      if (!cia_rw) begin
        cia_regs[cia_rs] <= cia_db_in;
        wr_seen <= wr_seen + 1;
      end else if (cia_rs == 4'hD) begin
        cia_regs[4'hD] <= 8'h00;
        rdd_seen <= rdd_seen + 1;
      end
    end
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  logic mon_en = 1'b0;
  logic exp_busy = 1'b0;
  logic exp_cs_n = 1'b1;

  // requesters
  logic [1:0] pend, rq, t_gr, t_we, f_val, f_we;
  logic [3:0] t_addr [2];
  logic [7:0] t_wd [2];
  logic [3:0] f_addr [2];
  logic [7:0] f_wd [2];
  int         t_ack [2];
  int         ph = 0;

  // reference model: one access lives from its grant to its ack
  logic [7:0] shadow [16];
  logic       m_active, m_port, m_last_gnt;
  logic [7:0] m_rdata;
  int         m_g, m_free, m_last_ack, m_wr, m_rdd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail_line(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    bad++;
    $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_port = 1'b0; m_last_gnt = 1'b1; m_rdata = 8'h00;
    m_g = 0; m_free = 0; m_last_ack = -1;
    pend = 2'b00; rq = 2'b00; t_gr = 2'b00; f_val = 2'b00;
    t_ack[0] = 32'h7fffffff; t_ack[1] = 32'h7fffffff;
    exp_busy = 1'b0; exp_cs_n = 1'b1;
    for (int i = 0; i < 16; i++) shadow[i] = reg_init(i);
  endtask

  // ---------------- monitor ----------------
  task automatic monitor_loop();
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset && mon_en) begin
        check("busy", busy, exp_busy);
        check("cs_n", cia_cs_n, exp_cs_n);
        if (ack0 || ack1) begin
          check("ack_onehot", ack0 & ack1, 0);
          if (exp_q.size() == 0) begin
            fail_line("ack_unexpected", {ack1, ack0}, 0);
          end else begin
            e = exp_q.pop_front();
            check("ack_port", ack1, e[53]);
            check("ack_cycle", cyc, e[31:0]);
            check("gnt_id", gnt_id, e[53]);
            check("rdata", rdata, e[39:32]);
            if (e[52]) check("cia_write", cia_regs[e[51:48]], e[47:40]);
          end
        end
      end
    end
  endtask

  // ---------------- driver: one clk of stimulus plus model ----------------
  // mode 0: random traffic with stray strobes; 1: both ports always request,
  // extra phi2_p mid-window; 2: only forced transactions.
  task automatic step(input int mode);
    int c;
    logic w;
    logic [3:0] a;
    logic [7:0] exp_rd;
    @(posedge clk); #1;
    c = cyc;
    for (int p = 0; p < 2; p++) begin
      if (pend[p] && c > t_ack[p]) begin
        pend[p] = 1'b0; rq[p] = 1'b0;
      end
      if (!pend[p]) begin
        if (f_val[p]) begin
          t_we[p] = f_we[p]; t_addr[p] = f_addr[p]; t_wd[p] = f_wd[p];
          f_val[p] = 1'b0;
          pend[p] = 1'b1; rq[p] = 1'b1; t_gr[p] = 1'b0; t_ack[p] = 32'h7fffffff;
        end else if (mode == 1 || (mode == 0 && $urandom_range(0, 2) == 0)) begin
          t_we[p] = 1'($urandom_range(0, 1));
          t_addr[p] = 4'($urandom_range(0, 15));
          t_wd[p] = 8'($urandom_range(0, 255));
          pend[p] = 1'b1; rq[p] = 1'b1; t_gr[p] = 1'b0; t_ack[p] = 32'h7fffffff;
        end
      end else if (mode == 0 && t_gr[p] && rq[p] && $urandom_range(0, 7) == 0) begin
        rq[p] = 1'b0;
      end
    end
    req0 = rq[0]; we0 = t_we[0]; addr0 = t_addr[0]; wdata0 = t_wd[0];
    req1 = rq[1]; we1 = t_we[1]; addr1 = t_addr[1]; wdata1 = t_wd[1];

    phi2_p = (ph == 0) || (mode == 1 && ph == 2) ||
             (mode == 0 && ph == 2 && $urandom_range(0, 5) == 0);
    phi2_n = (ph == 4) || (mode == 0 && ph == 6 && $urandom_range(0, 5) == 0);
    ph = (ph + 1) % 8;

    exp_busy = (m_active && m_g < c) || (c == m_last_ack);
    exp_cs_n = !(m_active && m_g < c);

    if (!m_active && c >= m_free && phi2_p && (rq[0] || rq[1])) begin
`ifdef CIA_ARB_RR_EN
      if (rq[0] && rq[1]) w = ~m_last_gnt;
      else w = ~rq[0];
`else
      w = ~rq[0];
`endif
      m_last_gnt = w; m_port = w; t_gr[w] = 1'b1;
      m_active = 1'b1; m_g = c;
    end else if (m_active && c > m_g && phi2_n) begin
      a = t_addr[m_port];
      if (t_we[m_port]) begin
        shadow[a] = t_wd[m_port];
        m_wr++;
        exp_rd = m_rdata;
      end else begin
        exp_rd = shadow[a];
        m_rdata = exp_rd;
        if (a == 4'hD) begin
          m_rdd++;
          shadow[a] = 8'h00;
        end
      end
      exp_q.push_back({m_port, t_we[m_port], a, t_wd[m_port], exp_rd, 32'(c + 1)});
      t_ack[m_port] = c + 1;
      m_last_ack = c + 1;
      m_active = 1'b0;
      m_free = c + 2;
    end
  endtask

  task automatic force_txn(input int p, input logic we, input logic [3:0] a, input logic [7:0] d);
    f_val[p] = 1'b1; f_we[p] = we; f_addr[p] = a; f_wd[p] = d;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((pend != 2'b00 || m_active || f_val != 2'b00) && n < 300) begin
      step(2);
      n++;
    end
    if (n >= 300) fail_line("drain_timeout", n, 0);
    step(2); step(2);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    m_wr = 0; m_rdd = 0;
    reset = 1'b1;
    phi2_p = 0; phi2_n = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_cs_n", cia_cs_n, 1);
    check("rst_rw", cia_rw, 1);
    check("rst_rs", cia_rs, 0);
    check("rst_db_in", cia_db_in, 0);
    check("rst_ack", {ack1, ack0}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_gnt_id", gnt_id, 1);
    check("rst_state", dbg_state, 0);
    mon_en = 1'b1;
    fork
      monitor_loop();
    join_none

    // CPU reads timer A low byte
    force_txn(0, 1'b0, 4'h4, 8'h00);
    drain();
    // debug unit writes ICR; then CPU reads ICR (clears it)
    force_txn(1, 1'b1, 4'hD, 8'h81);
    drain();
    force_txn(0, 1'b0, 4'hD, 8'h00);
    drain();
    // both ports request continuously for 4 phi2 periods
    repeat (32) step(1);
    drain();
    // random traffic
    repeat (800) step(0);
    drain();

    // reset while ARMED
    force_txn(0, 1'b0, 4'h3, 8'h00);
    n = 0;
    do begin
      step(2);
      n++;
    end while (!(m_active && m_g < cyc) && n < 40);
    if (n >= 40) fail_line("arm_timeout", n, 0);
    #2 reset = 1'b1;
    #1;
    check("midrst_cs_n", cia_cs_n, 1);
    check("midrst_busy", busy, 0);
    check("midrst_ack", {ack1, ack0}, 0);
    phi2_p = 0; phi2_n = 0; req0 = 0; req1 = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    force_txn(1, 1'b0, 4'h5, 8'h00);
    drain();
    repeat (300) step(0);
    drain();

    check("queue_empty", exp_q.size(), 0);
    check("wr_count", wr_seen, m_wr);
    check("icr_reads", rdd_seen, m_rdd);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
